// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around dm_arbiter.
// master: the requesters plus the memory (drives requests and read data).
// slave:  the arbiter (drives acks, captured read data and the memory controls).
interface dm_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] dm_addr;
    logic              dm_we;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    logic              busy;
    logic              grant_id;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output dm_rdata,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  dm_addr, dm_we, dm_wdata, busy, grant_id
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  dm_rdata,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output dm_addr, dm_we, dm_wdata, busy, grant_id
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access sequencer for the 128x8 data memory.
// Port 0 is the SPI datapath, port 1 the local host/debug requester.
// Each transaction runs IDLE -> ACCESS -> CAPTURE -> ACK; every output is registered.
module dm_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 8,
    parameter int SPI_PRIORITY = 1,
    parameter int MAX_WAIT     = 15
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              last_grant;
    logic              cur_we;
    logic              grant_r;
    logic              busy_r;
    logic              dm_we_r;
    logic [ADDR_W-1:0] dm_addr_r;
    logic [DATA_W-1:0] dm_wdata_r;
    logic              p0_ack_r;
    logic              p1_ack_r;
    logic [DATA_W-1:0] p0_rdata_r;
    logic [DATA_W-1:0] p1_rdata_r;
    logic              pick_p1;

    // Winner selection for the next IDLE edge: a lone requester always wins; ties use the configured policy.
    always_comb begin
        pick_p1 = 1'b0;
        if (SPI_PRIORITY != 0) begin
            pick_p1 = bus.p1_req && (!bus.p0_req || (wait_cnt == MAX_WAIT_C));
        end else begin
            pick_p1 = bus.p1_req && (!bus.p0_req || !last_grant);
        end
    end

    // Transaction sequencer: grants in IDLE, then walks through access, capture and the one-cycle ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            last_grant <= 1'b1;
            cur_we     <= 1'b0;
            grant_r    <= 1'b0;
            busy_r     <= 1'b0;
            dm_we_r    <= 1'b0;
            dm_addr_r  <= '0;
            dm_wdata_r <= '0;
            p0_ack_r   <= 1'b0;
            p1_ack_r   <= 1'b0;
            p0_rdata_r <= '0;
            p1_rdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        grant_r    <= pick_p1;
                        last_grant <= pick_p1;
                        dm_addr_r  <= pick_p1 ? bus.p1_addr  : bus.p0_addr;
                        dm_wdata_r <= pick_p1 ? bus.p1_wdata : bus.p0_wdata;
                        dm_we_r    <= pick_p1 ? bus.p1_we    : bus.p0_we;
                        cur_we     <= pick_p1 ? bus.p1_we    : bus.p0_we;
                        busy_r     <= 1'b1;
                        if (SPI_PRIORITY != 0) begin
                            if (pick_p1) begin
                                wait_cnt <= 4'd0;
                            end else if (bus.p1_req && (wait_cnt != MAX_WAIT_C)) begin
                                wait_cnt <= wait_cnt + 4'd1;
                            end
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    dm_we_r <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    if (!cur_we) begin
                        if (grant_r) begin
                            p1_rdata_r <= bus.dm_rdata;
                        end else begin
                            p0_rdata_r <= bus.dm_rdata;
                        end
                    end
                    if (grant_r) begin
                        p1_ack_r <= 1'b1;
                    end else begin
                        p0_ack_r <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    p0_ack_r <= 1'b0;
                    p1_ack_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dm_addr  = dm_addr_r;
    assign bus.dm_we    = dm_we_r;
    assign bus.dm_wdata = dm_wdata_r;
    assign bus.p0_ack   = p0_ack_r;
    assign bus.p1_ack   = p1_ack_r;
    assign bus.p0_rdata = p0_rdata_r;
    assign bus.p1_rdata = p1_rdata_r;
    assign bus.busy     = busy_r;
    assign bus.grant_id = grant_r;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a fixed-priority instance with a behavioural memory and
// an ack scoreboard, plus a round-robin instance exercised under continuous requests.
module tb_dm_arbiter;
    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    txn_t p0_pend[$];
    txn_t p1_pend[$];
    int   cycle          = 0;
    int   busy_cycles    = 0;
    int   we_cycles      = 0;
    int   last_ack_cycle = -1;
    bit   check_gap      = 1'b0;
    bit   prev_ack       = 1'b0;
    exp_t mon_e;
    logic [7:0] mon_rd;

    logic [7:0] mem    [128];
    logic [7:0] mem_rr [128];

    dm_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();
    dm_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus_rr ();

    dm_arbiter #(.ADDR_W(7), .DATA_W(8), .SPI_PRIORITY(1), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dm_arbiter #(.ADDR_W(7), .DATA_W(8), .SPI_PRIORITY(0), .MAX_WAIT(15)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory models: write on the edge ending ACCESS, read data one cycle after the address.
    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wdata;
        bus.dm_rdata <= mem[bus.dm_addr];
        if (bus_rr.dm_we) mem_rr[bus_rr.dm_addr] <= bus_rr.dm_wdata;
        bus_rr.dm_rdata <= mem_rr[bus_rr.dm_addr];
    end

    // Ack monitor for the fixed-priority instance: pops the scoreboard and checks ack hygiene.
    always @(negedge clk) begin
        if (!reset) begin
            cycle++;
            if (bus.busy) busy_cycles++;
            if (bus.dm_we) we_cycles++;
            if (bus.p0_ack || bus.p1_ack) begin
                total++;
                if (bus.p0_ack && bus.p1_ack) begin
                    bad++;
                    $display("[TB] FAIL dual_ack: p0_ack=%b p1_ack=%b, required one-hot", bus.p0_ack, bus.p1_ack);
                end
                total++;
                if (prev_ack) begin
                    bad++;
                    $display("[TB] FAIL ack_consecutive: ack high in two consecutive cycles at cycle %0d", cycle);
                end
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_ack: p0_ack=%b p1_ack=%b with nothing expected", bus.p0_ack, bus.p1_ack);
                end else begin
                    mon_e = sb.pop_front();
                    total++;
                    if (bus.p1_ack !== mon_e.port) begin
                        bad++;
                        $display("[TB] FAIL ack_port: got port %0d, required port %0d", bus.p1_ack, mon_e.port);
                    end
                    total++;
                    if (bus.grant_id !== mon_e.port) begin
                        bad++;
                        $display("[TB] FAIL grant_id: got %b, required %b", bus.grant_id, mon_e.port);
                    end
                    if (!mon_e.we) begin
                        mon_rd = mon_e.port ? bus.p1_rdata : bus.p0_rdata;
                        total++;
                        if (mon_rd !== mon_e.rdata) begin
                            bad++;
                            $display("[TB] FAIL rdata_port%0d: got %h, required %h", mon_e.port, mon_rd, mon_e.rdata);
                        end
                    end
                end
                if (check_gap && last_ack_cycle >= 0) begin
                    total++;
                    if (cycle - last_ack_cycle !== 4) begin
                        bad++;
                        $display("[TB] FAIL ack_spacing: got %0d cycles, required 4", cycle - last_ack_cycle);
                    end
                end
                last_ack_cycle = cycle;
            end
            prev_ack = bus.p0_ack || bus.p1_ack;
        end
    end

    task automatic drive_p0(input bit check_lat);
        txn_t t;
        int   n;
        bit   got;
        while (p0_pend.size() > 0) begin
            t = p0_pend.pop_front();
            bus.p0_we    = t.we;
            bus.p0_addr  = t.addr;
            bus.p0_wdata = t.wdata;
            bus.p0_req   = 1'b1;
            n   = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                got = bus.p0_ack;
            end
            if (!got) begin
                total++;
                bad++;
                $display("[TB] FAIL p0_timeout: no p0_ack after %0d cycles, required an ack", n);
                p0_pend.delete();
                break;
            end else if (check_lat) begin
                total++;
                if (n !== 4) begin
                    bad++;
                    $display("[TB] FAIL p0_latency: ack at cycle %0d after request, required 4", n);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.p0_req = 1'b0;
    endtask

    task automatic drive_p1(input bit check_lat);
        txn_t t;
        int   n;
        bit   got;
        while (p1_pend.size() > 0) begin
            t = p1_pend.pop_front();
            bus.p1_we    = t.we;
            bus.p1_addr  = t.addr;
            bus.p1_wdata = t.wdata;
            bus.p1_req   = 1'b1;
            n   = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                got = bus.p1_ack;
            end
            if (!got) begin
                total++;
                bad++;
                $display("[TB] FAIL p1_timeout: no p1_ack after %0d cycles, required an ack", n);
                p1_pend.delete();
                break;
            end else if (check_lat) begin
                total++;
                if (n !== 4) begin
                    bad++;
                    $display("[TB] FAIL p1_latency: ack at cycle %0d after request, required 4", n);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.p1_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.dm_we, bus.p0_ack, bus.p1_ack, bus.grant_id} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: busy/we/ack0/ack1/grant=%b, required 00000",
                     {bus.busy, bus.dm_we, bus.p0_ack, bus.p1_ack, bus.grant_id});
        end
        total++;
        if (bus.dm_addr !== 7'h00 || bus.dm_wdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_dm: addr=%h wdata=%h, required 00/00", bus.dm_addr, bus.dm_wdata);
        end
        total++;
        if (bus.p0_rdata !== 8'h00 || bus.p1_rdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_rdata: p0=%h p1=%h, required 00/00", bus.p0_rdata, bus.p1_rdata);
        end
        total++;
        if (bus_rr.busy !== 1'b0 || bus_rr.grant_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rr: busy=%b grant=%b, required 0/0", bus_rr.busy, bus_rr.grant_id);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_write_read_p0();
        p0_pend.push_back('{1'b1, 7'h03, 8'h5A});
        p0_pend.push_back('{1'b0, 7'h03, 8'h00});
        sb.push_back('{1'b0, 1'b1, 8'h00});
        sb.push_back('{1'b0, 1'b0, 8'h5A});
        we_cycles = 0;
        @(posedge clk);
        #1;
        drive_p0(1'b1);
        total++;
        if (we_cycles !== 1) begin
            bad++;
            $display("[TB] FAIL we_pulse: dm_we high %0d cycles, required 1", we_cycles);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL wr_rd_pending: %0d acks missing, required 0", sb.size());
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 16; i++) p0_pend.push_back('{1'b1, 7'(i), 8'(32'h20 + i)});
        p1_pend.push_back('{1'b1, 7'h40, 8'h99});
        p1_pend.push_back('{1'b0, 7'h05, 8'h00});
        for (int i = 0; i < 15; i++) sb.push_back('{1'b0, 1'b1, 8'h00});
        sb.push_back('{1'b1, 1'b1, 8'h00});
        sb.push_back('{1'b0, 1'b1, 8'h00});
        sb.push_back('{1'b1, 1'b0, 8'h25});
        check_gap      = 1'b1;
        last_ack_cycle = -1;
        @(posedge clk);
        #1;
        fork
            drive_p0(1'b0);
            drive_p1(1'b0);
        join
        check_gap = 1'b0;
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL priority_pending: %0d acks missing, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        bit exp_port[$];
        int n;
        int acks;
        int last;
        bit ep;
        for (int i = 0; i < 8; i++) exp_port.push_back((i % 2) == 1);
        @(posedge clk);
        #1;
        bus_rr.p0_we    = 1'b1;
        bus_rr.p0_addr  = 7'h01;
        bus_rr.p0_wdata = 8'h11;
        bus_rr.p1_we    = 1'b0;
        bus_rr.p1_addr  = 7'h01;
        bus_rr.p1_wdata = 8'h00;
        bus_rr.p0_req   = 1'b1;
        bus_rr.p1_req   = 1'b1;
        n    = 0;
        acks = 0;
        last = -1;
        while (acks < 8 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus_rr.p0_ack || bus_rr.p1_ack) begin
                ep = exp_port.pop_front();
                acks++;
                total++;
                if (bus_rr.p1_ack !== ep || bus_rr.p0_ack !== !ep) begin
                    bad++;
                    $display("[TB] FAIL rr_order: ack %0d p0_ack=%b p1_ack=%b, required port %0d",
                             acks, bus_rr.p0_ack, bus_rr.p1_ack, ep);
                end
                total++;
                if (bus_rr.grant_id !== ep) begin
                    bad++;
                    $display("[TB] FAIL rr_grant: got %b, required %b", bus_rr.grant_id, ep);
                end
                if (ep) begin
                    total++;
                    if (bus_rr.p1_rdata !== 8'h11) begin
                        bad++;
                        $display("[TB] FAIL rr_rdata: got %h, required 11", bus_rr.p1_rdata);
                    end
                end
                if (last >= 0) begin
                    total++;
                    if (n - last !== 4) begin
                        bad++;
                        $display("[TB] FAIL rr_spacing: got %0d cycles, required 4", n - last);
                    end
                end
                last = n;
            end
        end
        if (acks != 8) begin
            total++;
            bad++;
            $display("[TB] FAIL rr_timeout: got %0d acks, required 8", acks);
        end
        @(posedge clk);
        #1;
        bus_rr.p0_req = 1'b0;
        bus_rr.p1_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus_rr.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rr_idle: busy=%b, required 0", bus_rr.busy);
        end
    endtask

    task automatic test_cross_port();
        p1_pend.push_back('{1'b1, 7'h7F, 8'hC3});
        p0_pend.push_back('{1'b0, 7'h7F, 8'h00});
        sb.push_back('{1'b1, 1'b1, 8'h00});
        sb.push_back('{1'b0, 1'b0, 8'hC3});
        @(posedge clk);
        #1;
        drive_p1(1'b1);
        drive_p0(1'b1);
        total++;
        if (bus.p1_rdata !== 8'h25) begin
            bad++;
            $display("[TB] FAIL p1_rdata_kept: got %h, required 25", bus.p1_rdata);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL cross_pending: %0d acks missing, required 0", sb.size());
        end
    endtask

    task automatic test_reset_abort();
        int n;
        bit seen;
        int acks;
        p0_pend.push_back('{1'b1, 7'h10, 8'h33});
        sb.push_back('{1'b0, 1'b1, 8'h00});
        @(posedge clk);
        #1;
        drive_p0(1'b0);
        bus.p0_we    = 1'b1;
        bus.p0_addr  = 7'h10;
        bus.p0_wdata = 8'hFF;
        bus.p0_req   = 1'b1;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = bus.dm_we;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL abort_access: dm_we=%b within %0d cycles, required 1", seen, n);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus.dm_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_we: dm_we=%b right after reset, required 0", bus.dm_we);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_busy: busy=%b right after reset, required 0", bus.busy);
        end
        bus.p0_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.p0_ack) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("[TB] FAIL abort_ack: %0d acks after abort, required 0", acks);
        end
        p0_pend.push_back('{1'b0, 7'h10, 8'h00});
        sb.push_back('{1'b0, 1'b0, 8'h33});
        @(posedge clk);
        #1;
        drive_p0(1'b1);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL abort_pending: %0d acks missing, required 0", sb.size());
        end
    endtask

    task automatic test_single_p1_read();
        p1_pend.push_back('{1'b0, 7'h7F, 8'h00});
        sb.push_back('{1'b1, 1'b0, 8'hC3});
        @(posedge clk);
        #1;
        busy_cycles = 0;
        drive_p1(1'b1);
        total++;
        if (busy_cycles !== 3) begin
            bad++;
            $display("[TB] FAIL busy_len: busy for %0d cycles, required 3", busy_cycles);
        end
        total++;
        if (bus.grant_id !== 1'b1) begin
            bad++;
            $display("[TB] FAIL p1_grant_id: got %b, required 1", bus.grant_id);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL p1_pending: %0d acks missing, required 0", sb.size());
        end
    endtask

    // Top-level sequence of scenarios, ending with the one summary line.
    initial begin
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus_rr.p0_req = 1'b0; bus_rr.p0_we = 1'b0; bus_rr.p0_addr = '0; bus_rr.p0_wdata = '0;
        bus_rr.p1_req = 1'b0; bus_rr.p1_we = 1'b0; bus_rr.p1_addr = '0; bus_rr.p1_wdata = '0;
        #1 reset = 1'b1;
        $display("[TB] starting dm_arbiter bench");
        test_reset();
        test_write_read_p0();
        test_priority();
        test_round_robin();
        test_cross_port();
        test_reset_abort();
        test_single_p1_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer for the 128×8 data memory. It lets the SPI slave datapath (port 0) and a local host/debug requester (port 1) share the memory's single address/write port. It picks one requester per transaction, drives the memory address, write enable and write data, captures read data, and returns a one-cycle acknowledge. It sits between the SPI FSM/shift-register logic and the memory instance inside the SPI memory top level.

## Interface
Parameters:
- ADDR_W, 7, memory address width
- DATA_W, 8, memory data width
- SPI_PRIORITY, 1, arbitration mode: 1 = fixed priority to port 0 with a starvation guard; 0 = round-robin
- MAX_WAIT, 15, number of consecutive losses by port 1 (in fixed-priority mode) before it is forced to win; 4-bit counter

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  access request; held high until ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high
- p0_addr / p1_addr  in  ADDR_W  access address; stable while req is high
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req is high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_W  registered read data; valid from ack until the next read completes on that port
- dm_addr  out  ADDR_W  memory address (registered)
- dm_we  out  1  memory write enable
- dm_wdata  out  DATA_W  memory write data (registered)
- dm_rdata  in  DATA_W  memory read data; valid one cycle after dm_addr is presented
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  1  port currently or last granted

## Operation
- FSM states: IDLE → ACCESS → CAPTURE → ACK → IDLE. Every transition except IDLE→ACCESS is unconditional.
- IDLE: if any req is high at a clock edge:
  - latch the winner's addr/wdata into dm_addr/dm_wdata;
  - set grant_id;
  - go to ACCESS.
- ACCESS: dm_we = latched we. The memory writes on the edge that ends ACCESS. For a read, the address is stable this cycle.
- CAPTURE: dm_we = 0. On a read, dm_rdata is loaded into the granted pX_rdata at the end of this cycle. On a write, pX_rdata is unchanged.
- ACK: the granted pX_ack is 1 for exactly one cycle. The requester drops req on the edge that ends ACK, so req is already low in the next IDLE cycle.
- Arbitration with only one requester: that requester wins.
- Ties with SPI_PRIORITY=1:
  - port 0 wins, unless wait_cnt == MAX_WAIT, in which case port 1 wins;
  - wait_cnt increments (saturating at MAX_WAIT) each time port 1 requests and loses;
  - wait_cnt clears when port 1 is granted.
- Ties with SPI_PRIORITY=0: the port not in last_grant wins. last_grant updates at each grant.
- A request arriving while busy waits; it is evaluated at the next IDLE edge.
- Widths: addresses and data pass through unmodified; no wrap or arithmetic on the address.

## Timing
- Reset values: all outputs 0; state IDLE; wait_cnt 0; last_grant 1, so port 0 wins the first round-robin tie.
- Latency: req sampled high at IDLE edge N → ACCESS in cycle N+1 → CAPTURE N+2 → ack high in cycle N+3. Read data is valid in pX_rdata in the same cycle as ack.
- Throughput: one transaction per 4 cycles. Back-to-back requests from both ports alternate or follow priority, with no idle gap beyond the mandatory IDLE cycle.
- dm_we is high only during ACCESS for writes. It never overlaps CAPTURE, ACK or IDLE.
- p0_ack and p1_ack are never high together, and never for two consecutive cycles.
- Reset mid-operation:
  - state returns to IDLE immediately and asynchronously, and dm_we drops;
  - no ack is issued for the aborted transaction;
  - a write whose ACCESS-ending edge had not yet occurred is not performed;
  - the requester must re-request.
- Req dropped before ack is a protocol violation. The transaction still completes and acks.

## Test plan
- Port 0 write 0x5A at address 0x03, then read 0x03 → dm_we high one cycle in ACCESS; p0_ack 3 cycles after req sampled; p0_rdata = 0x5A with ack.
- Both ports request every cycle, SPI_PRIORITY=1, MAX_WAIT=15 → port 0 granted 15 times, then port 1 once; pattern repeats; wait_cnt returns to 0.
- Both ports request continuously, SPI_PRIORITY=0 → grants alternate 0,1,0,1 starting with port 0; acks spaced 4 cycles apart.
- Port 1 write 0xC3 at address 0x7F, then port 0 read 0x7F → p0_rdata = 0xC3; p1_rdata unchanged.
- Reset asserted during ACCESS of a port 0 write 0xFF to address 0x10 → dm_we drops immediately; no p0_ack; a later read of 0x10 returns the prior contents.
- Single port 1 read with port 0 idle → granted at first IDLE edge; busy high for exactly 3 cycles; grant_id = 1.
